// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD reader: state encodings,
// register-select values and default bus timing shared with lcd_interface.
package lcd_pkg;

    // Reader FSM states. CHECK is the poll/timeout decision. It is resolved on
    // the edge that leaves EN_LO_L, so the FSM never actually rests in it.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        EN_HI_H = 3'd2,
        EN_LO_H = 3'd3,
        EN_HI_L = 3'd4,
        EN_LO_L = 3'd5,
        CHECK   = 3'd6,
        DONE    = 3'd7
    } rd_state_e;

    // Phases of a single EN strobe.
    typedef enum logic [1:0] {
        STB_IDLE = 2'd0,
        STB_HI   = 2'd1,
        STB_LO   = 2'd2
    } stb_state_e;

    localparam logic RS_STATUS = 1'b0;
    localparam logic RS_DATA   = 1'b1;

    // Busy flag position in the status byte.
    localparam int BF_BIT = 7;

    // Default timings in 1 MHz LCD clock cycles.
    localparam int T_AS_CYC_DEF    = 1;
    localparam int T_EN_HI_CYC_DEF = 1;
    localparam int T_EN_LO_CYC_DEF = 1;
    localparam int MAX_POLLS_DEF   = 1000;

endpackage

// File: rtl/lcd_read_if_if.sv
// Host request/response and LCD pin bundle for the LCD reader.
//
// Handshake: a read is accepted on any clk edge where req && ready are both
// high. ready is high only while the reader is idle. A req seen while ready is
// low is ignored, and nothing is queued. The result comes back as a one-cycle
// done pulse. dout, busy_flag, addr and timeout are valid from that cycle and
// hold until the next read updates them.
interface lcd_read_if_if;
    logic       req;
    logic       rs_sel;
    logic       poll;
    logic       ready;
    logic       done;
    logic [7:0] dout;
    logic       busy_flag;
    logic [6:0] addr;
    logic       timeout;
    logic       rd_active;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [3:0] lcd_d_in;

    // Reader side.
    modport slave (
        input  req, rs_sel, poll, lcd_d_in,
        output ready, done, dout, busy_flag, addr, timeout,
        output rd_active, lcd_rs, lcd_rw, lcd_en
    );

    // Host / pin-mux side.
    modport master (
        output req, rs_sel, poll, lcd_d_in,
        input  ready, done, dout, busy_flag, addr, timeout,
        input  rd_active, lcd_rs, lcd_rw, lcd_en
    );
endinterface

// File: rtl/lcd_nibble_strobe.sv
// One EN pulse generator. EN stays high for T_EN_HI_CYC cycles and then low
// for T_EN_LO_CYC cycles. cap_o marks the edge that drops EN, which is where
// the data nibble is sampled. end_o marks the edge that ends the low time. A
// start on that same edge chains straight into the next pulse.
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int T_EN_HI_CYC = T_EN_HI_CYC_DEF,
    parameter int T_EN_LO_CYC = T_EN_LO_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       en_o,
    output logic       cap_o,
    output logic       end_o,
    output stb_state_e state_o
);

    localparam int HI_W = (T_EN_HI_CYC > 1) ? $clog2(T_EN_HI_CYC) : 1;
    localparam int LO_W = (T_EN_LO_CYC > 1) ? $clog2(T_EN_LO_CYC) : 1;
    localparam logic [HI_W-1:0] HI_LOAD = HI_W'(T_EN_HI_CYC - 1);
    localparam logic [LO_W-1:0] LO_LOAD = LO_W'(T_EN_LO_CYC - 1);

    stb_state_e      state_q;
    logic [HI_W-1:0] hi_cnt_q;
    logic [LO_W-1:0] lo_cnt_q;
    logic            en_q;

    assign cap_o   = (state_q == STB_HI) && (hi_cnt_q == '0);
    assign end_o   = (state_q == STB_LO) && (lo_cnt_q == '0);
    assign en_o    = en_q;
    assign state_o = state_q;

    // Strobe phase sequencing with down-counters for the high and low times.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= STB_IDLE;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            en_q     <= 1'b0;
        end else if (start_i) begin
            state_q  <= STB_HI;
            hi_cnt_q <= HI_LOAD;
            en_q     <= 1'b1;
        end else begin
            case (state_q)
                STB_HI: begin
                    if (hi_cnt_q == '0) begin
                        en_q     <= 1'b0;
                        lo_cnt_q <= LO_LOAD;
                        state_q  <= STB_LO;
                    end else begin
                        hi_cnt_q <= hi_cnt_q - 1'b1;
                    end
                end
                STB_LO: begin
                    if (lo_cnt_q == '0) begin
                        state_q <= STB_IDLE;
                    end else begin
                        lo_cnt_q <= lo_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= STB_IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_read_if.sv
// HD44780 4-bit bus reader. It performs an 8-bit read as two EN strobes, high
// nibble first. The read targets either the status register (BF/AC) or
// DDRAM/CGRAM data. It can optionally re-poll status until BF clears or the
// poll limit is reached.
module lcd_read_if
    import lcd_pkg::*;
#(
    parameter int T_AS_CYC    = T_AS_CYC_DEF,
    parameter int T_EN_HI_CYC = T_EN_HI_CYC_DEF,
    parameter int T_EN_LO_CYC = T_EN_LO_CYC_DEF,
    parameter int MAX_POLLS   = MAX_POLLS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    lcd_read_if_if.slave    bus,
    output rd_state_e       dbg_state_o
);

    localparam int AS_W = (T_AS_CYC > 1) ? $clog2(T_AS_CYC) : 1;
    localparam int CW   = $clog2(MAX_POLLS + 1);
    localparam logic [AS_W-1:0] AS_LOAD = AS_W'(T_AS_CYC - 1);
    localparam logic [CW-1:0]   MAX_C   = CW'(MAX_POLLS);

    rd_state_e       state_q;
    logic            rs_q;
    logic            poll_q;
    logic [AS_W-1:0] as_cnt_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q;
    logic            done_q;
    logic [7:0]      dout_q;
    logic            bf_q;
    logic [6:0]      addr_q;
    logic            timeout_q;
    logic            rd_active_q;
    logic            lcd_rs_q;
    logic            lcd_rw_q;

    logic            stb_start;
    logic            stb_en;
    logic            stb_cap;
    logic            stb_end;
    stb_state_e      stb_state;
    logic            status_poll;
    logic            repeat_rd;

    // Poll repeats apply only to status reads. The busy flag comes from the
    // high nibble of the read that is finishing now. cnt_q already counts that
    // read.
    assign status_poll = (rs_q == RS_STATUS) && poll_q;
    assign repeat_rd   = status_poll && dout_q[BF_BIT] && (cnt_q < MAX_C);

    // Launch an EN pulse at the end of setup, after the high-nibble low time,
    // and when a poll repeat chains straight into the next high nibble.
    assign stb_start = ((state_q == SETUP)   && (as_cnt_q == '0)) ||
                       ((state_q == EN_LO_H) && stb_end) ||
                       ((state_q == EN_LO_L) && stb_end && repeat_rd);

    lcd_nibble_strobe #(
        .T_EN_HI_CYC (T_EN_HI_CYC),
        .T_EN_LO_CYC (T_EN_LO_CYC)
    ) u_strobe (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (stb_start),
        .en_o    (stb_en),
        .cap_o   (stb_cap),
        .end_o   (stb_end),
        .state_o (stb_state)
    );

    // Read sequencer. It owns the pins from accept until the DONE -> IDLE edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rs_q        <= RS_STATUS;
            poll_q      <= 1'b0;
            as_cnt_q    <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            dout_q      <= '0;
            bf_q        <= 1'b0;
            addr_q      <= '0;
            timeout_q   <= 1'b0;
            rd_active_q <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req && ready_q) begin
                        rs_q        <= bus.rs_sel;
                        poll_q      <= bus.poll;
                        timeout_q   <= 1'b0;
                        cnt_q       <= '0;
                        as_cnt_q    <= AS_LOAD;
                        rd_active_q <= 1'b1;
                        lcd_rw_q    <= 1'b1;
                        lcd_rs_q    <= bus.rs_sel;
                        ready_q     <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (as_cnt_q == '0) begin
                        state_q <= EN_HI_H;
                    end else begin
                        as_cnt_q <= as_cnt_q - 1'b1;
                    end
                end
                EN_HI_H: begin
                    if (stb_cap) begin
                        dout_q[7:4] <= bus.lcd_d_in;
                        state_q     <= EN_LO_H;
                    end
                end
                EN_LO_H: begin
                    if (stb_end) begin
                        state_q <= EN_HI_L;
                    end
                end
                EN_HI_L: begin
                    if (stb_cap) begin
                        dout_q[3:0] <= bus.lcd_d_in;
                        if (cnt_q != MAX_C) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        state_q <= EN_LO_L;
                    end
                end
                EN_LO_L: begin
                    if (stb_end) begin
                        if (repeat_rd) begin
                            state_q <= EN_HI_H;
                        end else begin
                            done_q    <= 1'b1;
                            timeout_q <= status_poll && dout_q[BF_BIT] && (cnt_q == MAX_C);
                            if (rs_q == RS_STATUS) begin
                                bf_q   <= dout_q[BF_BIT];
                                addr_q <= dout_q[6:0];
                            end
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    rd_active_q <= 1'b0;
                    lcd_rw_q    <= 1'b0;
                    lcd_rs_q    <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.dout      = dout_q;
    assign bus.busy_flag = bf_q;
    assign bus.addr      = addr_q;
    assign bus.timeout   = timeout_q;
    assign bus.rd_active = rd_active_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_rw    = lcd_rw_q;
    // EN can only be high inside a read. The strobe only starts while
    // rd_active is set, and a reset clears both on the same edge.
    assign bus.lcd_en    = stb_en;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lcd_read_if.sv
// Bench for lcd_read_if: an LCD nibble model, a directed driver and a
// scoreboard monitor keyed on the done pulse.
module tb_lcd_read_if;
  import lcd_pkg::*;

  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rd_state_e dbg_state;

  lcd_read_if_if bus();

  lcd_read_if #(.MAX_POLLS(MAXP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int edge_n = 0;
  int e0 = 0;
  int en_cnt = 0;
  logic [3:0] nib_q[$];
  logic [3:0] stuck_nib = 4'h0;
  logic [16:0] exp_q[$];
  int lat_q[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  // LCD model: present the next nibble while EN is high.
  always @(posedge bus.lcd_en) begin
    en_cnt++;
    if (nib_q.size() > 0) bus.lcd_d_in = nib_q.pop_front();
    else bus.lcd_d_in = stuck_nib;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [16:0] e;
    int l;
    chk("en_owner", {31'd0, bus.lcd_en & ~bus.rd_active}, 32'd0);
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("done_result", {15'd0, bus.dout, bus.busy_flag, bus.addr, bus.timeout}, {15'd0, e});
        chk("done_latency", edge_n - e0, l);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [7:0] d, input logic bf, input logic [6:0] a,
                          input logic to, input int lat);
    exp_q.push_back({d, bf, a, to});
    lat_q.push_back(lat);
  endtask

  // Raise req and return #1 after the accept edge (E0).
  task automatic start_read(input logic rs, input logic pl, input bit hold);
    int g = 0;
    @(negedge clk);
    bus.req = 1'b1;
    bus.rs_sel = rs;
    bus.poll = pl;
    while (!bus.ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_wait: ready stayed 0 expected 1");
    end
    @(posedge clk);
    #1;
    e0 = edge_n;
    if (!hold) bus.req = 1'b0;
  endtask

  // Wait for done, note whether RS stayed high, then check the IDLE edge.
  task automatic wait_done(input int budget, output logic rs_hold);
    int g = 0;
    rs_hold = 1'b1;
    while (!bus.done && g < budget) begin
      @(negedge clk);
      if (!bus.lcd_rs) rs_hold = 1'b0;
      g++;
    end
    if (!bus.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_wait: no done within %0d cycles expected done", budget);
    end
    @(posedge clk);
    #1;
    chk("idle_ready", {31'd0, bus.ready}, 32'd1);
    chk("idle_rd_active", {31'd0, bus.rd_active}, 32'd0);
    chk("idle_rw", {31'd0, bus.lcd_rw}, 32'd0);
    chk("idle_rs", {31'd0, bus.lcd_rs}, 32'd0);
    chk("idle_done", {31'd0, bus.done}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic rs_hold;
    int en0;
    int e0_a;

    bus.req = 1'b0;
    bus.rs_sel = 1'b0;
    bus.poll = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);
    chk("rst_bf", {31'd0, bus.busy_flag}, 32'd0);
    chk("rst_addr", {25'd0, bus.addr}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    chk("rst_rd_active", {31'd0, bus.rd_active}, 32'd0);
    chk("rst_pins", {29'd0, bus.lcd_rs, bus.lcd_rw, bus.lcd_en}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});

    // T1: reset in the middle of a read (asserted after E2)
    nib_q.push_back(4'h3);
    nib_q.push_back(4'h9);
    start_read(RS_STATUS, 1'b0, 1'b0);
    chk("t1_e0_rw", {31'd0, bus.lcd_rw}, 32'd1);
    chk("t1_e0_ready", {31'd0, bus.ready}, 32'd0);
    @(posedge clk); #1;
    chk("t1_e1_en", {31'd0, bus.lcd_en}, 32'd1);
    @(posedge clk); #1;
    chk("t1_e2_en", {31'd0, bus.lcd_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t1_rst_en", {31'd0, bus.lcd_en}, 32'd0);
    chk("t1_rst_rw", {31'd0, bus.lcd_rw}, 32'd0);
    chk("t1_rst_rd_active", {31'd0, bus.rd_active}, 32'd0);
    chk("t1_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("t1_rst_dout", {24'd0, bus.dout}, 32'd0);
    chk("t1_rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nib_q.delete();
    repeat (4) @(negedge clk);

    // T2: status read, no poll -> 0x85
    nib_q.push_back(4'h8);
    nib_q.push_back(4'h5);
    push_exp(8'h85, 1'b1, 7'h05, 1'b0, 5);
    en0 = en_cnt;
    start_read(RS_STATUS, 1'b0, 1'b0);
    chk("t2_rs_status", {31'd0, bus.lcd_rs}, 32'd0);
    wait_done(40, rs_hold);
    chk("t2_en_pulses", en_cnt - en0, 2);

    // T3: data read -> 0x41, BF/AC keep the previous status read
    nib_q.push_back(4'h4);
    nib_q.push_back(4'h1);
    push_exp(8'h41, 1'b1, 7'h05, 1'b0, 5);
    en0 = en_cnt;
    start_read(RS_DATA, 1'b0, 1'b0);
    chk("t3_rs_e0", {31'd0, bus.lcd_rs}, 32'd1);
    wait_done(40, rs_hold);
    chk("t3_rs_hold", {31'd0, rs_hold}, 32'd1);
    chk("t3_en_pulses", en_cnt - en0, 2);

    // T4: poll, BF=1 for three reads, then 0x40
    for (int i = 0; i < 3; i++) begin
      nib_q.push_back(4'h8);
      nib_q.push_back(4'h0);
    end
    nib_q.push_back(4'h4);
    nib_q.push_back(4'h0);
    push_exp(8'h40, 1'b0, 7'h40, 1'b0, 17);
    en0 = en_cnt;
    start_read(RS_STATUS, 1'b1, 1'b0);
    wait_done(80, rs_hold);
    chk("t4_en_pulses", en_cnt - en0, 8);

    // T5: poll limit (4) with the bus stuck at 0xFF
    stuck_nib = 4'hF;
    push_exp(8'hFF, 1'b1, 7'h7F, 1'b1, 17);
    en0 = en_cnt;
    start_read(RS_STATUS, 1'b1, 1'b0);
    wait_done(80, rs_hold);
    chk("t5_en_pulses", en_cnt - en0, 8);
    chk("t5_timeout_hold", {31'd0, bus.timeout}, 32'd1);
    stuck_nib = 4'h0;

    // T6: req pulse during SETUP is ignored; held req starts the next read
    nib_q.push_back(4'h2);
    nib_q.push_back(4'h3);
    nib_q.push_back(4'h6);
    nib_q.push_back(4'h7);
    push_exp(8'h23, 1'b0, 7'h23, 1'b0, 5);
    push_exp(8'h67, 1'b0, 7'h23, 1'b0, 5);
    en0 = en_cnt;
    start_read(RS_STATUS, 1'b0, 1'b0);
    e0_a = e0;
    chk("t6_timeout_clear", {31'd0, bus.timeout}, 32'd0);
    chk("t6_state_setup", {29'd0, dbg_state}, {29'd0, SETUP});
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    bus.req = 1'b1;
    bus.rs_sel = RS_DATA;
    bus.poll = 1'b0;
    wait_done(40, rs_hold);
    @(posedge clk); #1;
    e0 = edge_n;
    bus.req = 1'b0;
    chk("t6_second_accept_edge", edge_n - e0_a, 7);
    chk("t6_second_state", {29'd0, dbg_state}, {29'd0, SETUP});
    chk("t6_gap_en_low", {31'd0, bus.lcd_en}, 32'd0);
    wait_done(40, rs_hold);
    chk("t6_en_pulses", en_cnt - en0, 4);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
